// File: rtl/pointwise_frame_scheduler.sv
// Frame controller for a non-stallable flush/read_en/write_valid pointwise unit: bridges a
// valid/ready pixel source, counts pixels per frame and flags schedule violations.
module pointwise_frame_scheduler #(
   parameter int DW           = 16,
   parameter int CW           = 16,
   parameter int NUM_IN       = 4096,
   parameter int NUM_OUT      = 4096,
   parameter int FLUSH_CYCLES = 1,
   parameter int TIMEOUT      = 65535
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code,
   output logic [CW-1:0] in_count,
   output logic [CW-1:0] out_count,
   input  logic          src_valid,
   input  logic [DW-1:0] src_data,
   output logic          src_ready,
   output logic          dut_flush,
   input  logic          dut_read_en,
   output logic [DW-1:0] dut_read_data,
   input  logic          dut_write_valid,
   input  logic [DW-1:0] dut_write_data,
   output logic          sink_valid,
   output logic [DW-1:0] sink_data
);

   typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

   localparam logic [CW-1:0] NIN     = CW'(NUM_IN);
   localparam logic [CW-1:0] NOUT    = CW'(NUM_OUT);
   localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE     = CW'(1);

   localparam logic [1:0] EC_NONE      = 2'd0;
   localparam logic [1:0] EC_UNDERFLOW = 2'd1;
   localparam logic [1:0] EC_OVERRUN   = 2'd2;
   localparam logic [1:0] EC_TIMEOUT   = 2'd3;

   state_t        state_q, state_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] wd_q, wd_d;
   logic [CW-1:0] fl_q, fl_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          sink_valid_q, sink_valid_d;
   logic [DW-1:0] sink_data_q, sink_data_d;

   logic          active;
   logic          silent;
   logic          underflow;
   logic          overrun;
   logic          wd_expire;
   logic [CW-1:0] wd_inc;

   always_comb begin
      state_d      = state_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      wd_d         = wd_q;
      fl_d         = fl_q;
      err_code_d   = err_code_q;
      sink_valid_d = 1'b0;
      sink_data_d  = sink_data_q;

      active    = (state_q == S_RUN) || (state_q == S_DRAIN);
      silent    = active && !dut_read_en && !dut_write_valid;
      wd_inc    = wd_q + ONE;
      underflow = (state_q == S_RUN) && dut_read_en && !src_valid;
      overrun   = active && ((dut_read_en && (in_cnt_q == NIN)) ||
                             (dut_write_valid && (out_cnt_q == NOUT)));
      wd_expire = silent && (wd_inc == TO_LIM);

      case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_d    = S_FLUSH;
               in_cnt_d   = '0;
               out_cnt_d  = '0;
               wd_d       = '0;
               fl_d       = '0;
               err_code_d = EC_NONE;
            end
         end
         S_FLUSH: begin
            if (fl_q == FL_LAST) state_d = S_RUN;
            else                 fl_d    = fl_q + ONE;
         end
         S_RUN, S_DRAIN: begin
            // A violating cycle is not counted or forwarded: counters freeze at the fault.
            if (underflow) begin
               state_d    = S_ERR;
               err_code_d = EC_UNDERFLOW;
            end else if (overrun) begin
               state_d    = S_ERR;
               err_code_d = EC_OVERRUN;
            end else if (wd_expire) begin
               state_d    = S_ERR;
               err_code_d = EC_TIMEOUT;
            end else begin
               if (dut_read_en)     in_cnt_d  = in_cnt_q + ONE;
               if (dut_write_valid) begin
                  out_cnt_d   = out_cnt_q + ONE;
                  sink_data_d = dut_write_data;
               end
               sink_valid_d = dut_write_valid;
               wd_d         = silent ? wd_inc : '0;
               if ((in_cnt_d == NIN) && (out_cnt_d == NOUT)) state_d = S_DONE;
               else if (in_cnt_d == NIN)                     state_d = S_DRAIN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         wd_q         <= '0;
         fl_q         <= '0;
         err_code_q   <= EC_NONE;
         sink_valid_q <= 1'b0;
         sink_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         wd_q         <= wd_d;
         fl_q         <= fl_d;
         err_code_q   <= err_code_d;
         sink_valid_q <= sink_valid_d;
         sink_data_q  <= sink_data_d;
      end
   end

   assign busy          = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done          = (state_q == S_DONE);
   assign err           = (state_q == S_ERR);
   assign err_code      = err_code_q;
   assign in_count      = in_cnt_q;
   assign out_count     = out_cnt_q;
   assign dut_flush     = (state_q == S_FLUSH);
   assign src_ready     = dut_read_en && (state_q == S_RUN) && (in_cnt_q < NIN);
   assign dut_read_data = src_data;
   assign sink_valid    = sink_valid_q;
   assign sink_data     = sink_data_q;

endmodule

// File: tb/tb_pointwise_frame_scheduler.sv
// Randomized frame-level bench for pointwise_frame_scheduler: each scenario is a per-cycle
// schedule of unit strobes annotated with the behaviour the frame rules predict.
module tb_pointwise_frame_scheduler;

   localparam int DW = 16;
   localparam int CW = 16;
   localparam int NI = 16;
   localparam int NO = 16;
   localparam int FC = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          busy, done, err;
   logic [1:0]    err_code;
   logic [CW-1:0] in_count, out_count;
   logic          src_valid, src_ready;
   logic [DW-1:0] src_data, dut_read_data;
   logic          dut_flush, dut_read_en, dut_write_valid;
   logic [DW-1:0] dut_write_data;
   logic          sink_valid;
   logic [DW-1:0] sink_data;

   always #5 clk = ~clk;

   pointwise_frame_scheduler #(
      .DW(DW), .CW(CW), .NUM_IN(NI), .NUM_OUT(NO), .FLUSH_CYCLES(FC), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .in_count(in_count), .out_count(out_count),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .dut_flush(dut_flush), .dut_read_en(dut_read_en), .dut_read_data(dut_read_data),
      .dut_write_valid(dut_write_valid), .dut_write_data(dut_write_data),
      .sink_valid(sink_valid), .sink_data(sink_data)
   );

   // One schedule entry: strobes driven plus the expected forward / src_ready / start.
   typedef struct {
      bit rd; bit wr; bit sv; bit fw; bit rdy; bit st;
   } cyc_t;
   cyc_t sched[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input bit rd, input bit wr, input bit sv, input bit fw, input bit rdy,
                      input bit st);
      sched.push_back('{rd, wr, sv, fw, rdy, st});
   endtask

   task automatic idle_inputs();
      start = 1'b0; dut_read_en = 1'b0; dut_write_valid = 1'b0;
      src_valid = 1'b1; src_data = '0; dut_write_data = '0;
   endtask

   task automatic run_sched(input int done_at);
      for (int t = 0; t < sched.size(); t++) begin
         logic [DW-1:0] wd;
         wd              = DW'($urandom);
         dut_read_en     = sched[t].rd;
         dut_write_valid = sched[t].wr;
         dut_write_data  = wd;
         src_valid       = sched[t].sv;
         src_data        = DW'($urandom);
         start           = sched[t].st;
         @(negedge clk);
         check_eq("src_ready", 32'(src_ready), 32'(sched[t].rdy));
         if (sched[t].rd) check_eq("read_data", 32'(dut_read_data), 32'(src_data));
         tick();
         check_eq("sink_valid", 32'(sink_valid), 32'(sched[t].fw));
         if (sched[t].fw) check_eq("sink_data", 32'(sink_data), 32'(wd));
         check_eq("done", 32'(done), 32'(t == done_at));
      end
      idle_inputs();
      sched.delete();
   endtask

   // Start pulse, then both unit strobes held high through the flush (they must be ignored).
   task automatic start_frame();
      start = 1'b1; dut_read_en = 1'b1; dut_write_valid = 1'b1; src_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < FC; i++) begin
         @(negedge clk);
         check_eq("flush", 32'(dut_flush), 32'd1);
         check_eq("flush_busy", 32'(busy), 32'd1);
         check_eq("flush_rdy", 32'(src_ready), 32'd0);
         check_eq("flush_sink", 32'(sink_valid), 32'd0);
         tick();
      end
      idle_inputs();
      check_eq("flush_end", 32'(dut_flush), 32'd0);
      check_eq("start_err", 32'(err), 32'd0);
      check_eq("start_code", 32'(err_code), 32'd0);
      check_eq("start_in", 32'(in_count), 32'd0);
      check_eq("start_out", 32'(out_count), 32'd0);
   endtask

   // mode 0: all reads then all writes; 1: random interleave; 2: interleave ending in a joint cycle.
   task automatic build_frame(input int mode, input int st_at);
      int r, w, sil, t, rl, wl;
      r = 0; w = 0; sil = 0; t = 0;
      rl = (mode == 2) ? NI - 1 : NI;
      wl = (mode == 2) ? NO - 1 : NO;
      while (r < rl || w < wl) begin
         bit rd, wr;
         if (mode == 0) begin
            rd = (r < rl) && ($urandom_range(0, 2) != 0);
            wr = (r >= rl) && ($urandom_range(0, 2) != 0);
         end else begin
            rd = (r < rl) && ($urandom_range(0, 1) == 1);
            wr = (w < wl) && ($urandom_range(0, 1) == 1);
         end
         if (!rd && !wr && sil >= 3) begin
            if (r < rl) rd = 1'b1;
            else        wr = 1'b1;
         end
         sil = (rd || wr) ? 0 : sil + 1;
         r += int'(rd);
         w += int'(wr);
         add(rd, wr, 1'b1, wr, rd, (t == st_at));
         t++;
      end
      if (mode == 2) add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic end_checks();
      check_eq("end_in", 32'(in_count), NI);
      check_eq("end_out", 32'(out_count), NO);
      check_eq("end_err", 32'(err), 32'd0);
      check_eq("end_busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("done_start_busy", 32'(busy), 32'd0);
      check_eq("done_once", 32'(done), 32'd0);
      check_eq("hold_in", 32'(in_count), NI);
      check_eq("hold_out", 32'(out_count), NO);
   endtask

   task automatic check_err(input string tag, input int code, input int nin, input int nout);
      check_eq({tag, "_err"}, 32'(err), 32'd1);
      check_eq({tag, "_code"}, 32'(err_code), code);
      check_eq({tag, "_in"}, 32'(in_count), nin);
      check_eq({tag, "_out"}, 32'(out_count), nout);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_code", 32'(err_code), 32'd0);
      check_eq("rst_in", 32'(in_count), 32'd0);
      check_eq("rst_out", 32'(out_count), 32'd0);
      check_eq("rst_flush", 32'(dut_flush), 32'd0);
      check_eq("rst_sink", 32'(sink_valid), 32'd0);

      // Clean frames: sequential, then joint final strobes.
      start_frame(); build_frame(0, -1); run_sched(sched.size() - 1); end_checks();
      start_frame(); build_frame(2, -1); run_sched(sched.size() - 1); end_checks();

      // Underflow on the 5th read, then strobes in ERR must not move the counters.
      start_frame();
      repeat (4) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_sched(-1);
      check_err("underflow", 1, 4, 0);
      repeat (2) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1 ^ 1'b1);
      run_sched(-1);
      check_err("frozen", 1, 4, 0);

      // Restart from ERR, with a start pulse mid-frame that must be ignored.
      start_frame(); build_frame(1, 5); run_sched(sched.size() - 1); end_checks();

      // Overrun by a 17th write while inputs are still pending.
      start_frame();
      repeat (8)  add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (16) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_sched(-1);
      check_err("ovr_wr", 2, 8, 16);

      // Overrun by a 17th read while draining.
      start_frame();
      repeat (16) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (4)  add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_sched(-1);
      check_err("ovr_rd", 2, 16, 4);

      // Underflow and overrun in the same cycle: underflow wins.
      start_frame();
      repeat (4)  add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (16) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run_sched(-1);
      check_err("prio", 1, 4, 16);

      // Watchdog: a read clears it; the 8th consecutive silent cycle trips it.
      start_frame();
      repeat (3) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (6) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (7) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_sched(-1);
      check_eq("wd_pre_err", 32'(err), 32'd0);
      check_eq("wd_pre_busy", 32'(busy), 32'd1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_sched(-1);
      check_err("timeout", 3, 4, 0);

      // Reset mid-RUN after 7 reads, then a clean frame.
      start_frame();
      repeat (7) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      run_sched(-1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_done", 32'(done), 32'd0);
      check_eq("mrst_err", 32'(err), 32'd0);
      check_eq("mrst_code", 32'(err_code), 32'd0);
      check_eq("mrst_in", 32'(in_count), 32'd0);
      check_eq("mrst_out", 32'(out_count), 32'd0);
      check_eq("mrst_flush", 32'(dut_flush), 32'd0);
      check_eq("mrst_sinkv", 32'(sink_valid), 32'd0);
      check_eq("mrst_sinkd", 32'(sink_data), 32'd0);
      start_frame(); build_frame(1, -1); run_sched(sched.size() - 1); end_checks();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pointwise_frame_scheduler.md
Name: pointwise_frame_scheduler

Overview:
- Frame-level controller for a statically scheduled pointwise compute unit: one flush/read_en/write_valid stream-in, stream-out kernel.
- Issues the unit's flush and bridges an upstream valid/ready pixel source onto the unit's read_en port.
- Counts consumed input and produced output pixels, forwards results to a sink, and reports frame completion or a schedule violation.
- The unit cannot stall: the scheduler checks the source keeps pace; it does not throttle the unit.

Parameters:
DW, 16, pixel data width
CW, 16, width of the pixel counters and watchdog counter
NUM_IN, 4096, input pixels per frame (1..2^CW-1)
NUM_OUT, 4096, output pixels per frame (1..2^CW-1)
FLUSH_CYCLES, 1, cycles dut_flush is held high at frame start (>=1)
TIMEOUT, 65535, idle cycles in RUN/DRAIN with no read_en and no write_valid before timeout error

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle frame start request
busy  out  1  high in FLUSH, RUN, DRAIN
done  out  1  one-cycle pulse at frame completion
err  out  1  sticky error flag
err_code  out  2  0 none, 1 underflow, 2 overrun, 3 timeout
in_count  out  CW  input pixels consumed this frame
out_count  out  CW  output pixels produced this frame
src_valid  in  1  upstream pixel available
src_data  in  DW  upstream pixel
src_ready  out  1  upstream pop strobe
dut_flush  out  1  flush to compute unit
dut_read_en  in  1  unit consumes a pixel this cycle
dut_read_data  out  DW  pixel to unit
dut_write_valid  in  1  unit produces a pixel this cycle
dut_write_data  in  DW  pixel from unit
sink_valid  out  1  registered output strobe
sink_data  out  DW  registered output pixel

Behaviour:
- Reset values: state IDLE; busy, done, err, dut_flush, sink_valid = 0; err_code, in_count, out_count, sink_data = 0. rst in any state aborts the frame on the next edge.
- States: IDLE, FLUSH, RUN, DRAIN, DONE, ERR.
- IDLE or ERR:
  - start -> FLUSH; clear counters, watchdog, err and err_code.
  - start while busy or in DONE is ignored.
- FLUSH:
  - dut_flush = 1 for exactly FLUSH_CYCLES cycles, then -> RUN.
  - dut_read_en or dut_write_valid in FLUSH is ignored (not counted, not forwarded).
- src_ready = dut_read_en & (state==RUN) & (in_count<NUM_IN), combinational.
- dut_read_data = src_data, combinational, zero latency.
- RUN:
  - Each dut_read_en increments in_count.
  - dut_read_en with src_valid=0 -> ERR, code 1.
  - When in_count reaches NUM_IN and out_count<NUM_OUT -> DRAIN.
- RUN and DRAIN:
  - Each dut_write_valid increments out_count.
  - sink_valid/sink_data = dut_write_valid/dut_write_data delayed one cycle.
  - dut_read_en with in_count==NUM_IN -> ERR, code 2.
  - dut_write_valid with out_count==NUM_OUT -> ERR, code 2.
- Watchdog:
  - Counts cycles in RUN/DRAIN with neither dut_read_en nor dut_write_valid; cleared by either strobe.
  - Reaching TIMEOUT -> ERR, code 3.
- Completion: in_count==NUM_IN and out_count==NUM_OUT (including both final strobes in the same cycle) -> DONE.
- DONE: done=1 for one cycle, -> IDLE. Counters hold final values until the next start.
- Error priority in the same cycle: underflow > overrun > timeout.
- ERR: counters frozen, sink_valid=0, err=1 until rst or start.

Test Plan:
- NUM_IN=NUM_OUT=16, FLUSH_CYCLES=2, src_valid always 1, unit reads pixels 0..15 then writes 16 results -> dut_flush high 2 cycles, 16 src_ready pulses, sink shows 16 pixels each 1 cycle after write_valid, done pulses once, in_count=out_count=16, err=0.
- Same configuration, src_valid dropped on the 5th dut_read_en -> err=1, err_code=1, in_count=4, busy=0, no done.
- Final dut_read_en and final dut_write_valid in the same cycle -> RUN goes directly to DONE, no DRAIN cycle, done next cycle.
- 17th dut_write_valid after 16 -> err_code=2. Separately, TIMEOUT=8 with 8 silent cycles in RUN -> err_code=3 on the 8th cycle.
- rst asserted mid-RUN after 7 reads -> next cycle IDLE, all outputs 0. A following start runs a clean 16/16 frame.
- start pulsed during RUN is ignored (counters continue). start in ERR clears err and re-enters FLUSH.
